// File: rtl/aes_parameters.sv
// Shared types and constants for the AES-256 inverse round scheduler.
package aes_parameters;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      FINAL,
      OUT
   } sched_state_t;

   localparam int AES256_NR = 14;

endpackage

// File: rtl/inv_cipher_round_sched.sv
// AES-256 decrypt sequencer: loops one block NR times through two inverse round pipelines.
// Optional INV_SCHED_WATCHDOG_EN adds a WAIT timeout with a sticky wd_err output.
module inv_cipher_round_sched
   import aes_parameters::*;
#(
   parameter int NR      = AES256_NR,
   parameter int RND_LAT = 4,
   parameter int KEY_AW  = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [127:0]      s_tdata,
   input  logic              s_tvalid,
   input  logic              s_tlast,
   output logic              s_tready,
   output logic [127:0]      m_tdata,
   output logic              m_tvalid,
   output logic              m_tlast,
   input  logic              m_tready,
   output logic [KEY_AW-1:0] key_rd_addr,
   input  logic [127:0]      key_rd_data,
   output logic [127:0]      first_tdata,
   output logic              first_tvalid,
   input  logic [127:0]      first_out_tdata,
   input  logic              first_out_tvalid,
   output logic [127:0]      mid_tdata,
   output logic              mid_tvalid,
   input  logic [127:0]      mid_out_tdata,
   input  logic              mid_out_tvalid,
   output logic [127:0]      rnd_key,
   output logic              busy
`ifdef INV_SCHED_WATCHDOG_EN
   ,output logic             wd_err
`endif
);

   localparam int PW = $clog2(NR + 1);

   sched_state_t      state_q, state_d;
   logic [PW-1:0]     pass_cnt;
   logic [127:0]      state_reg;
   logic              tlast_q;
   logic              rnd_strobe;
   logic [127:0]      rnd_data;
   logic              last_pass;
   logic [KEY_AW-1:0] next_key;
   logic              wd_fire;

   // Only the instance owning the current pass may advance the FSM.
   assign rnd_strobe = (pass_cnt == '0) ? first_out_tvalid : mid_out_tvalid;
   assign rnd_data   = (pass_cnt == '0) ? first_out_tdata  : mid_out_tdata;
   assign last_pass  = (int'(pass_cnt) == NR - 1);

   // Key for the following pass (key 0 after the last pass), presented a cycle early
   // so the RAM data is valid on the next issue or in FINAL.
   assign next_key   = KEY_AW'(NR - 1 - int'(pass_cnt));

   assign first_tdata = state_reg;
   assign mid_tdata   = state_reg;
   assign rnd_key     = key_rd_data;

`ifdef INV_SCHED_WATCHDOG_EN
   logic [7:0] wd_cnt;

   assign wd_fire = (state_q == WAIT) && !rnd_strobe && (wd_cnt == 8'(2 * RND_LAT - 1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wd_cnt <= '0;
         wd_err <= 1'b0;
      end else begin
         wd_cnt <= (state_q == WAIT) ? wd_cnt + 8'd1 : 8'd0;
         if (wd_fire) wd_err <= 1'b1;
      end
   end
`else
   assign wd_fire = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      s_tready     = 1'b0;
      busy         = 1'b1;
      first_tvalid = 1'b0;
      mid_tvalid   = 1'b0;
      key_rd_addr  = '0;
      unique case (state_q)
         IDLE: begin
            s_tready    = 1'b1;
            busy        = 1'b0;
            key_rd_addr = KEY_AW'(NR);
            if (s_tvalid) state_d = ISSUE;
         end
         ISSUE: begin
            key_rd_addr = next_key;
            if (pass_cnt == '0) first_tvalid = 1'b1;
            else                mid_tvalid   = 1'b1;
            state_d = WAIT;
         end
         WAIT: begin
            key_rd_addr = next_key;
            if (rnd_strobe)   state_d = last_pass ? FINAL : ISSUE;
            else if (wd_fire) state_d = IDLE;
         end
         FINAL: state_d = OUT;
         OUT: begin
            if (m_tready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         pass_cnt  <= '0;
         state_reg <= '0;
         tlast_q   <= 1'b0;
         m_tdata   <= '0;
         m_tvalid  <= 1'b0;
         m_tlast   <= 1'b0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            IDLE: begin
               if (s_tvalid) begin
                  state_reg <= s_tdata;
                  tlast_q   <= s_tlast;
               end
            end
            WAIT: begin
               if (rnd_strobe) begin
                  state_reg <= rnd_data;
                  pass_cnt  <= pass_cnt + 1'b1;
               end else if (wd_fire) begin
                  pass_cnt  <= '0;
               end
            end
            FINAL: begin
               m_tdata  <= state_reg ^ key_rd_data;
               m_tvalid <= 1'b1;
               m_tlast  <= tlast_q;
            end
            OUT: begin
               if (m_tready) begin
                  m_tvalid <= 1'b0;
                  pass_cnt <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_inv_cipher_round_sched.sv
// Bench for inv_cipher_round_sched: models the two inverse round pipelines, the key RAM
// and a FIPS-197 inverse cipher reference.
module tb_inv_cipher_round_sched;

   logic         clk = 1'b0;
   logic         resetn;
   logic [127:0] s_tdata;
   logic         s_tvalid, s_tlast, s_tready;
   logic [127:0] m_tdata;
   logic         m_tvalid, m_tlast, m_tready;
   logic [3:0]   key_rd_addr;
   logic [127:0] key_rd_data;
   logic [127:0] first_tdata, first_out_tdata, mid_tdata, mid_out_tdata, rnd_key;
   logic         first_tvalid, first_out_tvalid, mid_tvalid, mid_out_tvalid, busy;
`ifdef INV_SCHED_WATCHDOG_EN
   logic         wd_err;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   inv_cipher_round_sched dut (
      .clk(clk), .resetn(resetn),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
      .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
      .key_rd_addr(key_rd_addr), .key_rd_data(key_rd_data),
      .first_tdata(first_tdata), .first_tvalid(first_tvalid),
      .first_out_tdata(first_out_tdata), .first_out_tvalid(first_out_tvalid),
      .mid_tdata(mid_tdata), .mid_tvalid(mid_tvalid),
      .mid_out_tdata(mid_out_tdata), .mid_out_tvalid(mid_out_tvalid),
      .rnd_key(rnd_key), .busy(busy)
`ifdef INV_SCHED_WATCHDOG_EN
      , .wd_err(wd_err)
`endif
   );

   // ---------------- AES helpers ----------------
   logic [7:0]   sbox  [256];
   logic [7:0]   isbox [256];
   logic [127:0] rk      [15];
   logic [127:0] key_mem [16];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] aa = a;
      logic [7:0] bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return 8'((b << n) | (b >> (8 - n)));
   endfunction

   task automatic init_sbox();
      logic [7:0] inv, s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
         sbox[x]  = s;
         isbox[s] = 8'(x);
      end
   endtask

   function automatic logic [127:0] isr(input logic [127:0] s);
      logic [127:0] o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127 - 8*(r + 4*((c + r) % 4)) -: 8] = s[127 - 8*(r + 4*c) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] isb(input logic [127:0] s);
      logic [127:0] o = '0;
      for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = isbox[s[127 - 8*i -: 8]];
      return o;
   endfunction

   function automatic logic [127:0] imc(input logic [127:0] s);
      logic [127:0] o = '0;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127 - 32*c -: 8];
         a1 = s[119 - 32*c -: 8];
         a2 = s[111 - 32*c -: 8];
         a3 = s[103 - 32*c -: 8];
         o[127 - 32*c -: 32] = {
            gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9),
            gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13),
            gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11),
            gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14)};
      end
      return o;
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
   endfunction

   task automatic expand(input logic [255:0] k);
      logic [31:0] w [60];
      logic [31:0] t;
      logic [7:0]  rc = 8'h01;
      for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
      for (int i = 8; i < 60; i++) begin
         t = w[i-1];
         if (i % 8 == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end else if (i % 8 == 4) begin
            t = subw(t);
         end
         w[i] = w[i-8] ^ t;
      end
      for (int r = 0; r < 15; r++) begin
         rk[r]      = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         key_mem[r] = rk[r];
      end
      key_mem[15] = '0;
   endtask

   // Textbook FIPS-197 InvCipher using the expanded key in rk[].
   function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
      logic [127:0] s = ct ^ rk[14];
      for (int r = 13; r >= 1; r--) s = imc(isb(isr(s)) ^ rk[r]);
      return isb(isr(s)) ^ rk[0];
   endfunction

   // ---------------- environment models ----------------
   always @(posedge clk) key_rd_data <= key_mem[key_rd_addr];

   logic [127:0] fd [4];
   logic [127:0] md [4];
   logic [3:0]   fv, mv;
   int           mid_iss;
   logic         kill_en = 1'b0;
   logic         mid_spur = 1'b0;

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fv <= '0; mv <= '0; mid_iss <= 0;
      end else begin
         fv    <= {fv[2:0], first_tvalid};
         mv    <= {mv[2:0], mid_tvalid};
         fd[0] <= isb(isr(first_tdata ^ rnd_key));
         md[0] <= isb(isr(imc(mid_tdata ^ rnd_key)));
         for (int i = 1; i < 4; i++) begin
            fd[i] <= fd[i-1];
            md[i] <= md[i-1];
         end
         if (mid_tvalid) mid_iss <= mid_iss + 1;
      end
   end

   assign first_out_tvalid = fv[3];
   assign first_out_tdata  = fd[3];
   assign mid_out_tvalid   = (mv[3] && !(kill_en && mid_iss == 3)) || mid_spur;
   assign mid_out_tdata    = mid_spur ? 128'hdeadbeef_0bad_f00d_5a5a_a5a5_1234_5678 : md[3];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Sends one block and reports what came back; comparisons live in the tests.
   task automatic do_block(input logic [127:0] ct, input logic last, input int stall,
                           input int spur_cyc, output logic [127:0] got, output logic got_last,
                           output int lat, output int gap, output bit ready_ok,
                           output bit stable_ok);
      int n = 0;
      int cyc;
      s_tdata = ct; s_tlast = last; s_tvalid = 1'b1; m_tready = 1'b0;
      while (!s_tready && n < 200) begin step(); n++; end
      step();
      s_tvalid = 1'b0; s_tdata = {$urandom, $urandom, $urandom, $urandom}; s_tlast = 1'b0;
      cyc = 1; ready_ok = 1'b1; stable_ok = 1'b1;
      while (!m_tvalid && cyc < 300) begin
         if (s_tready) ready_ok = 1'b0;
         mid_spur = (cyc == spur_cyc);
         step();
         cyc++;
      end
      mid_spur = 1'b0;
      lat = cyc; got = m_tdata; got_last = m_tlast;
      if (s_tready) ready_ok = 1'b0;
      repeat (stall) begin
         step(); cyc++;
         if (m_tdata !== got || m_tvalid !== 1'b1 || s_tready !== 1'b0) stable_ok = 1'b0;
      end
      m_tready = 1'b1;
      step(); cyc++;
      m_tready = 1'b0;
      gap = cyc;
      if (s_tready !== 1'b1 || m_tvalid !== 1'b0) ready_ok = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      resetn = 1'b0;
      #3;
      checks += 7;
      if (m_tvalid !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid: got %b exp 0", m_tvalid); end
      if (m_tdata !== '0) begin errors++; $display("FAIL reset_m_tdata: got %h exp 0", m_tdata); end
      if (m_tlast !== 1'b0) begin errors++; $display("FAIL reset_m_tlast: got %b exp 0", m_tlast); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
      if (first_tvalid !== 1'b0 || mid_tvalid !== 1'b0) begin
         errors++; $display("FAIL reset_issue: got %b%b exp 00", first_tvalid, mid_tvalid); end
      if (key_rd_addr !== 4'd14) begin errors++; $display("FAIL reset_key_addr: got %0d exp 14", key_rd_addr); end
      if (s_tready !== 1'b1) begin errors++; $display("FAIL reset_s_tready: got %b exp 1", s_tready); end
      @(negedge clk); resetn = 1'b1;
      step();
   endtask

   task automatic test_fips();
      logic [127:0] got; logic gl; int lat, gap; bit rok, sok;
      do_block(128'h8ea2b7ca516745bfeafc49904b496089, 1'b0, 0, -1, got, gl, lat, gap, rok, sok);
      checks += 4;
      if (got !== 128'h00112233445566778899aabbccddeeff) begin
         errors++; $display("FAIL fips_data: got %h exp 00112233445566778899aabbccddeeff", got); end
      if (lat !== 72) begin errors++; $display("FAIL fips_latency: got %0d exp 72", lat); end
      if (gl !== 1'b0) begin errors++; $display("FAIL fips_tlast: got %b exp 0", gl); end
      if (!rok) begin errors++; $display("FAIL fips_s_tready: got early/late ready exp low during block"); end
   endtask

   task automatic test_back_to_back();
      logic [127:0] got, ct; logic gl; int lat, gap; bit rok, sok;
      for (int b = 0; b < 2; b++) begin
         ct = {$urandom, $urandom, $urandom, $urandom};
         do_block(ct, (b == 1), 0, -1, got, gl, lat, gap, rok, sok);
         checks += 4;
         if (got !== ref_decrypt(ct)) begin
            errors++; $display("FAIL b2b_data%0d: got %h exp %h", b, got, ref_decrypt(ct)); end
         if (gl !== (b == 1)) begin errors++; $display("FAIL b2b_tlast%0d: got %b exp %0d", b, gl, b); end
         if (gap !== 73) begin errors++; $display("FAIL b2b_ready_gap%0d: got %0d exp 73", b, gap); end
         if (!rok) begin errors++; $display("FAIL b2b_s_tready%0d: got ready outside IDLE exp low", b); end
      end
   endtask

   task automatic test_backpressure();
      logic [127:0] got, ct; logic gl; int lat, gap; bit rok, sok;
      ct = {$urandom, $urandom, $urandom, $urandom};
      do_block(ct, 1'b1, 20, -1, got, gl, lat, gap, rok, sok);
      checks += 4;
      if (!sok) begin errors++; $display("FAIL stall_stable: got output change exp stable for 20 cycles"); end
      if (got !== ref_decrypt(ct)) begin errors++; $display("FAIL stall_data: got %h exp %h", got, ref_decrypt(ct)); end
      if (gap !== 93) begin errors++; $display("FAIL stall_gap: got %0d exp 93", gap); end
      if (!rok) begin errors++; $display("FAIL stall_ready: got bad s_tready exp low until release"); end
   endtask

   task automatic test_spurious();
      logic [127:0] got, ct; logic gl; int lat, gap; bit rok, sok;
      ct = {$urandom, $urandom, $urandom, $urandom};
      do_block(ct, 1'b0, 0, 3, got, gl, lat, gap, rok, sok);
      checks += 2;
      if (got !== ref_decrypt(ct)) begin errors++; $display("FAIL spurious_data: got %h exp %h", got, ref_decrypt(ct)); end
      if (lat !== 72) begin errors++; $display("FAIL spurious_latency: got %0d exp 72", lat); end
   endtask

   task automatic test_reset_mid_block();
      logic [127:0] got, ct; logic gl; int lat, gap, n; bit rok, sok;
      s_tdata = {$urandom, $urandom, $urandom, $urandom}; s_tvalid = 1'b1; s_tlast = 1'b1;
      n = 0;
      while (!s_tready && n < 200) begin step(); n++; end
      step(); s_tvalid = 1'b0;
      n = 0;
      while (mid_iss < 7 && n < 200) begin step(); n++; end
      step();
      checks += 1;
      if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b exp 1", busy); end
      #2; resetn = 1'b0; #1;
      checks += 4;
      if (m_tvalid !== 1'b0) begin errors++; $display("FAIL midrst_m_tvalid: got %b exp 0", m_tvalid); end
      if (key_rd_addr !== 4'd14) begin errors++; $display("FAIL midrst_key_addr: got %0d exp 14", key_rd_addr); end
      if (busy !== 1'b0 || s_tready !== 1'b1) begin
         errors++; $display("FAIL midrst_idle: got busy=%b ready=%b exp 0/1", busy, s_tready); end
      if (mid_tvalid !== 1'b0 || first_tvalid !== 1'b0) begin
         errors++; $display("FAIL midrst_issue: got %b%b exp 00", first_tvalid, mid_tvalid); end
      @(negedge clk); resetn = 1'b1;
      step();
      ct = {$urandom, $urandom, $urandom, $urandom};
      do_block(ct, 1'b0, 0, -1, got, gl, lat, gap, rok, sok);
      checks += 2;
      if (got !== ref_decrypt(ct)) begin errors++; $display("FAIL midrst_next_data: got %h exp %h", got, ref_decrypt(ct)); end
      if (gl !== 1'b0) begin errors++; $display("FAIL midrst_next_tlast: got %b exp 0", gl); end
   endtask

   task automatic test_random_keys();
      logic [127:0] got, ct; logic gl; int lat, gap; bit rok, sok;
      for (int k = 0; k < 3; k++) begin
         expand({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
         ct = {$urandom, $urandom, $urandom, $urandom};
         do_block(ct, 1'(k & 1), 0, -1, got, gl, lat, gap, rok, sok);
         checks += 2;
         if (got !== ref_decrypt(ct)) begin errors++; $display("FAIL rkey_data%0d: got %h exp %h", k, got, ref_decrypt(ct)); end
         if (lat !== 72) begin errors++; $display("FAIL rkey_latency%0d: got %0d exp 72", k, lat); end
      end
   endtask

`ifdef INV_SCHED_WATCHDOG_EN
   task automatic test_watchdog();
      logic [127:0] got, ct; logic gl; int lat, gap, n, cyc, first_err; bit rok, sok, seen_mv;
      @(negedge clk); resetn = 1'b0;
      @(negedge clk); resetn = 1'b1;
      step();
      checks += 1;
      if (wd_err !== 1'b0) begin errors++; $display("FAIL wd_reset: got %b exp 0", wd_err); end
      kill_en = 1'b1;
      s_tdata = {$urandom, $urandom, $urandom, $urandom}; s_tvalid = 1'b1; s_tlast = 1'b0;
      n = 0;
      while (!s_tready && n < 200) begin step(); n++; end
      step(); s_tvalid = 1'b0;
      cyc = 1; first_err = 0; seen_mv = 1'b0;
      while (cyc <= 40) begin
         if (wd_err && first_err == 0) first_err = cyc;
         if (m_tvalid) seen_mv = 1'b1;
         step(); cyc++;
      end
      checks += 3;
      if (first_err !== 25) begin errors++; $display("FAIL wd_timing: got %0d exp 25", first_err); end
      if (seen_mv) begin errors++; $display("FAIL wd_no_output: got m_tvalid=1 exp never"); end
      if (busy !== 1'b0 || s_tready !== 1'b1) begin
         errors++; $display("FAIL wd_idle: got busy=%b ready=%b exp 0/1", busy, s_tready); end
      kill_en = 1'b0;
      ct = {$urandom, $urandom, $urandom, $urandom};
      do_block(ct, 1'b0, 0, -1, got, gl, lat, gap, rok, sok);
      checks += 2;
      if (got !== ref_decrypt(ct)) begin errors++; $display("FAIL wd_recover_data: got %h exp %h", got, ref_decrypt(ct)); end
      if (wd_err !== 1'b1) begin errors++; $display("FAIL wd_sticky: got %b exp 1", wd_err); end
   endtask
`endif

   initial begin
      resetn = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
      init_sbox();
      expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
      test_reset();
      test_fips();
      test_back_to_back();
      test_backpressure();
      test_spurious();
      test_reset_mid_block();
      test_random_keys();
`ifdef INV_SCHED_WATCHDOG_EN
      test_watchdog();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
